// File: rtl/nand_pkg.sv
// Shared constants and state encoding for the NAND flash target model.
// Opcodes, timing parameters and status byte used by the FSM and busy timer.
package nand_pkg;

  localparam int PAGE_BYTES = 512;
  localparam int PAGES      = 512;
  localparam int COL_W      = 9;
  localparam int ROW_W      = 9;
  localparam int TMR_W      = 7;

  localparam int T_R    = 16;
  localparam int T_PROG = 64;
  localparam int T_RST  = 4;

  localparam logic [TMR_W-1:0] LD_R    = TMR_W'(T_R - 1);
  localparam logic [TMR_W-1:0] LD_PROG = TMR_W'(T_PROG - 1);
  localparam logic [TMR_W-1:0] LD_RST  = TMR_W'(T_RST - 1);

  localparam logic [7:0] CMD_READ0   = 8'h00;
  localparam logic [7:0] CMD_READ1   = 8'h01;
  localparam logic [7:0] CMD_PROG    = 8'h80;
  localparam logic [7:0] CMD_CONFIRM = 8'h10;
  localparam logic [7:0] CMD_STATUS  = 8'h70;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  localparam logic [7:0] STATUS_READY = 8'h40;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_READ_BUSY,
    ST_READ_DATA,
    ST_PROG_DATA,
    ST_PROG_BUSY,
    ST_STATUS,
    ST_RST_BUSY
  } nand_state_e;

endpackage

// File: rtl/nand_busy_timer.sv
// Ready/busy down-counter: load arms busy, ready returns the cycle after the count hits zero.
// expire_o flags that final busy cycle so the FSM can take its completion action.
module nand_busy_timer
  import nand_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [TMR_W-1:0] load_val_i,
  output logic             busy_o,
  output logic             expire_o,
  output logic             rb_o
);

  logic [TMR_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;

  always_comb begin
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      busy_d = 1'b1;
    end else if (busy_q) begin
      if (cnt_q == '0) busy_d = 1'b0;
      else             cnt_d  = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  // A reload in the last busy cycle (FFh) must not also fire the completion action.
  assign expire_o = busy_q && (cnt_q == '0) && !load_i;
  assign busy_o   = busy_q;
  assign rb_o     = !busy_q;

endmodule

// File: rtl/nand_flash_target.sv
// Flash-device side of the small-page NAND pin interface: decodes bus cycles,
// streams page reads from / programs into an external synchronous array port.
module nand_flash_target
  import nand_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  inout  wire  [7:0]  F_IO,
  input  logic        F_CLE,
  input  logic        F_ALE,
  input  logic        F_WEN,
  input  logic        F_REN,
  output logic        F_RB,
  output logic [17:0] mem_addr,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata
);

  nand_state_e state_q, state_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [1:0]       addr_cnt_q, addr_cnt_d;
  logic             prog_q, prog_d;
  logic             cle_q, ale_q, wen_q, ren_q;
  logic             mem_re_q, mem_re_d;
  logic             mem_we_q, mem_we_d;
  logic [17:0]      mem_addr_q, mem_addr_d;
  logic [7:0]       mem_wdata_q, mem_wdata_d;
  logic             rd_pend_q;
  logic [7:0]       dout_q;

  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_busy, tmr_expire, tmr_rb;

  logic we_rise, ren_rise, is_cmd, is_addr, is_data, cmd_ok;
  logic io_oe;
  logic [7:0] io_dout;

  assign we_rise  = !wen_q && F_WEN;
  assign ren_rise = !ren_q && F_REN;
  assign is_cmd   = we_rise &&  cle_q && !ale_q;
  assign is_addr  = we_rise && !cle_q &&  ale_q;
  assign is_data  = we_rise && !cle_q && !ale_q;
  // While busy the device only listens to status and reset.
  assign cmd_ok   = is_cmd && (!tmr_busy || F_IO == CMD_STATUS || F_IO == CMD_RESET);

  nand_busy_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .busy_o     (tmr_busy),
    .expire_o   (tmr_expire),
    .rb_o       (tmr_rb)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    addr_cnt_d  = addr_cnt_q;
    prog_d      = prog_q;
    mem_re_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    tmr_load    = 1'b0;
    tmr_val     = '0;

    if (cmd_ok) begin
      case (F_IO)
        CMD_READ0, CMD_READ1, CMD_PROG: begin
          state_d    = ST_ADDR;
          col_d[8]   = (F_IO == CMD_READ1);
          prog_d     = (F_IO == CMD_PROG);
          addr_cnt_d = 2'd0;
        end
        CMD_STATUS: state_d = ST_STATUS;
        CMD_RESET: begin
          state_d  = ST_RST_BUSY;
          tmr_load = 1'b1;
          tmr_val  = LD_RST;
        end
        CMD_CONFIRM: begin
          if (state_q == ST_PROG_DATA) begin
            state_d  = ST_PROG_BUSY;
            tmr_load = 1'b1;
            tmr_val  = LD_PROG;
          end
        end
        default: ;
      endcase
    end else begin
      case (state_q)
        ST_ADDR: begin
          if (is_addr) begin
            case (addr_cnt_q)
              2'd0: begin
                col_d[7:0] = F_IO;
                addr_cnt_d = 2'd1;
              end
              2'd1: begin
                row_d[7:0] = F_IO;
                addr_cnt_d = 2'd2;
              end
              default: begin
                row_d[8]   = F_IO[0];
                addr_cnt_d = 2'd0;
                if (prog_q) begin
                  state_d = ST_PROG_DATA;
                end else begin
                  state_d  = ST_READ_BUSY;
                  tmr_load = 1'b1;
                  tmr_val  = LD_R;
                end
              end
            endcase
          end
        end
        ST_READ_BUSY: begin
          if (tmr_expire) begin
            state_d    = ST_READ_DATA;
            mem_re_d   = 1'b1;
            mem_addr_d = {row_q, col_q};
          end
        end
        ST_READ_DATA: begin
          // Prefetch the next byte as soon as the host releases REN.
          if (ren_rise) begin
            col_d      = col_q + 1'b1;
            mem_re_d   = 1'b1;
            mem_addr_d = {row_q, col_q + 1'b1};
          end
        end
        ST_PROG_DATA: begin
          if (is_data) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = {row_q, col_q};
            mem_wdata_d = F_IO;
            col_d       = col_q + 1'b1;
          end
        end
        ST_PROG_BUSY, ST_RST_BUSY: begin
          if (tmr_expire) state_d = ST_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      addr_cnt_q  <= '0;
      prog_q      <= 1'b0;
      cle_q       <= 1'b0;
      ale_q       <= 1'b0;
      wen_q       <= 1'b1;
      ren_q       <= 1'b1;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pend_q   <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      addr_cnt_q  <= addr_cnt_d;
      prog_q      <= prog_d;
      cle_q       <= F_CLE;
      ale_q       <= F_ALE;
      wen_q       <= F_WEN;
      ren_q       <= F_REN;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rd_pend_q   <= mem_re_q;
      if (rd_pend_q) dout_q <= mem_rdata;
    end
  end

  assign io_oe   = (state_q == ST_READ_DATA || state_q == ST_STATUS) && !F_REN;
  assign io_dout = (state_q == ST_STATUS) ? (tmr_rb ? STATUS_READY : 8'h00) : dout_q;
  assign F_IO    = io_oe ? io_dout : 8'hzz;

  assign F_RB      = tmr_rb;
  assign mem_re    = mem_re_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_nand_flash_target.sv
// Randomized bench for nand_flash_target: host-side pin driver, array model and
// expected-content reference checked against reads, writes and ready/busy timing.
module tb_nand_flash_target;
  import nand_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  wire  [7:0]  f_io;
  logic        host_oe = 1'b0;
  logic [7:0]  host_d = 8'h00;
  logic        cle = 1'b0, ale = 1'b0, wen = 1'b1, ren = 1'b1;
  logic        f_rb;
  logic [17:0] mem_addr;
  logic        mem_re, mem_we;
  logic [7:0]  mem_rdata, mem_wdata;

  assign f_io = host_oe ? host_d : 8'hzz;

  nand_flash_target dut (
    .clk       (clk),
    .rst       (rst),
    .F_IO      (f_io),
    .F_CLE     (cle),
    .F_ALE     (ale),
    .F_WEN     (wen),
    .F_REN     (ren),
    .F_RB      (f_rb),
    .mem_addr  (mem_addr),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .mem_we    (mem_we),
    .mem_wdata (mem_wdata)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int we_cyc = 0;
  int rb_fall_cyc = -1, rb_rise_cyc = -1, n_fall = 0, n_re = 0;
  logic rb_prev = 1'b1;
  logic [31:0] seed;

  // Array content: untouched locations follow a seeded hash, written ones are stored.
  logic [7:0] sram [0:262143];
  logic       sram_wr [0:262143];
  logic [7:0] ref_mem [0:262143];
  logic       ref_wr [0:262143];
  logic [17:0] exp_wa[$], got_wa[$];
  logic [7:0]  exp_wd[$], got_wd[$];

  function automatic logic [7:0] init_val(input logic [17:0] a);
    logic [31:0] h;
    h = {14'b0, a} * 32'h9E37_79B1 + seed;
    return h[23:16] ^ h[7:0];
  endfunction

  function automatic logic [7:0] ref_val(input logic [17:0] a);
    return ref_wr[a] ? ref_mem[a] : init_val(a);
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_re) mem_rdata <= sram_wr[mem_addr] ? sram[mem_addr] : init_val(mem_addr);
    if (mem_we) begin
      sram[mem_addr]    <= mem_wdata;
      sram_wr[mem_addr] <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (mem_re) n_re++;
    if (mem_we) begin
      got_wa.push_back(mem_addr);
      got_wd.push_back(mem_wdata);
    end
    if (!f_rb && rb_prev) begin rb_fall_cyc = cyc; n_fall++; end
    if (f_rb && !rb_prev) rb_rise_cyc = cyc;
    rb_prev = f_rb;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus_cycle(input logic c, input logic a, input logic [7:0] d);
    @(posedge clk); #1;
    cle = c; ale = a; host_d = d; host_oe = 1'b1; wen = 1'b0;
    repeat (2) @(posedge clk); #1;
    wen = 1'b1; we_cyc = cyc;
    repeat (2) @(posedge clk); #1;
    host_oe = 1'b0; cle = 1'b0; ale = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] op);
    bus_cycle(1'b1, 1'b0, op);
  endtask

  task automatic addr3(input logic [7:0] col_lo, input logic [8:0] row);
    bus_cycle(1'b0, 1'b1, col_lo);
    bus_cycle(1'b0, 1'b1, row[7:0]);
    bus_cycle(1'b0, 1'b1, {7'b0, row[8]});
  endtask

  task automatic read_byte(output logic [7:0] b);
    @(posedge clk); #1; ren = 1'b0;
    @(negedge clk); b = f_io;
    @(posedge clk); #1; ren = 1'b1;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_ready(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (f_rb !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_rb"}, f_rb, 1'b1);
    @(posedge clk); #1;
  endtask

  task automatic check_writes(input string tag);
    int n;
    check({tag, "_nwr"}, got_wa.size(), exp_wa.size());
    n = (got_wa.size() < exp_wa.size()) ? got_wa.size() : exp_wa.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_waddr"}, got_wa[i], exp_wa[i]);
      check({tag, "_wdata"}, got_wd[i], exp_wd[i]);
    end
    got_wa.delete(); got_wd.delete(); exp_wa.delete(); exp_wd.delete();
  endtask

  // Read nb bytes starting at {row, col}; col[8] comes from the opcode.
  task automatic do_read(input string tag, input logic [7:0] op, input logic [7:0] col_lo,
                         input logic [8:0] row, input int nb);
    logic [8:0] c;
    logic [7:0] b;
    int w;
    c = {(op == CMD_READ1), col_lo};
    cmd(op);
    addr3(col_lo, row);
    w = we_cyc;
    wait_ready(tag);
    check({tag, "_busy_start"}, rb_fall_cyc, w + 1);
    check({tag, "_busy_len"}, rb_rise_cyc - rb_fall_cyc, T_R);
    repeat (3) @(posedge clk);
    for (int i = 0; i < nb; i++) begin
      read_byte(b);
      check({tag, "_rd"}, b, ref_val({row, c}));
      c = c + 1'b1;
    end
  endtask

  task automatic send_data(input logic [7:0] d, input logic [8:0] row, inout logic [8:0] c);
    bus_cycle(1'b0, 1'b0, d);
    exp_wa.push_back({row, c});
    exp_wd.push_back(d);
    ref_mem[{row, c}] = d;
    ref_wr[{row, c}]  = 1'b1;
    c = c + 1'b1;
  endtask

  task automatic do_prog(input string tag, input logic [7:0] col_lo, input logic [8:0] row,
                         input int nb);
    logic [8:0] c;
    int w;
    c = {1'b0, col_lo};
    cmd(CMD_PROG);
    addr3(col_lo, row);
    for (int i = 0; i < nb; i++) send_data(8'($urandom), row, c);
    cmd(CMD_CONFIRM);
    w = we_cyc;
    wait_ready(tag);
    check({tag, "_busy_start"}, rb_fall_cyc, w + 1);
    check({tag, "_busy_len"}, rb_rise_cyc - rb_fall_cyc, T_PROG);
    check_writes(tag);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [7:0] b;
    logic [8:0] c, row;
    logic [7:0] col_lo;
    int w, re0, fall0, nb;
    seed = $urandom;
    for (int i = 0; i < 262144; i++) begin
      sram_wr[i] = 1'b0;
      ref_wr[i]  = 1'b0;
    end

    // Reset then idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    re0 = n_re;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("idle_rb", f_rb, 1'b1);
    check("idle_re", n_re - re0, 0);
    check("idle_we", got_wa.size(), 0);

    // Full-page read of row 261 including wrap back to column 0
    do_read("rd_page", CMD_READ0, 8'h05 - 8'h05, 9'd261, 1);
    c = 9'd1;
    for (int i = 0; i < 512; i++) begin
      read_byte(b);
      check("rd_page_seq", b, ref_val({9'd261, c}));
      c = c + 1'b1;
    end

    // Second-half read: column 272 of row 2
    cmd(CMD_READ1);
    addr3(8'h10, 9'd2);
    wait_ready("rd_half");
    repeat (3) @(posedge clk);
    read_byte(b);
    check("rd_half_c272", b, ref_val({9'd2, 9'd272}));

    // Program A5h,5Ah at row 7 col 0
    cmd(CMD_PROG);
    addr3(8'h00, 9'd7);
    c = 9'd0;
    send_data(8'hA5, 9'd7, c);
    send_data(8'h5A, 9'd7, c);
    cmd(CMD_CONFIRM);
    w = we_cyc;

    // Status while busy, then after expiry
    cmd(CMD_STATUS);
    @(posedge clk); #1; ren = 1'b0;
    @(negedge clk);
    check("status_busy", f_io, 8'h00);
    @(posedge clk); #1; ren = 1'b1;
    wait_ready("prog_st");
    check("prog_busy_start", rb_fall_cyc, w + 1);
    check("prog_busy_end", rb_rise_cyc, w + 1 + T_PROG);
    @(posedge clk); #1; ren = 1'b0;
    @(negedge clk);
    check("status_ready", f_io, STATUS_READY);
    @(posedge clk); #1; ren = 1'b1;
    check_writes("prog_a5");
    do_read("rd_a5", CMD_READ0, 8'h00, 9'd7, 2);

    // FFh in the middle of a program busy period
    cmd(CMD_PROG);
    addr3(8'h20, 9'd8);
    c = 9'd32;
    send_data(8'h3C, 9'd8, c);
    cmd(CMD_CONFIRM);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("prog2_busy", f_rb, 1'b0);
    cmd(CMD_RESET);
    w = we_cyc;
    wait_ready("rst_busy");
    check("rst_busy_end", rb_rise_cyc, w + 1 + T_RST);
    check_writes("prog2");
    do_read("rd_prog2", CMD_READ0, 8'h20, 9'd8, 1);

    // Synchronous reset during a program busy period
    cmd(CMD_PROG);
    addr3(8'h40, 9'd9);
    c = 9'd64;
    send_data(8'hC3, 9'd9, c);
    cmd(CMD_CONFIRM);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_rb", f_rb, 1'b1);
    check_writes("prog3");

    // Read aborted after one address cycle by a program command
    re0 = n_re;
    fall0 = n_fall;
    cmd(CMD_READ0);
    bus_cycle(1'b0, 1'b1, 8'h33);
    cmd(CMD_PROG);
    addr3(8'h12, 9'd300);
    c = 9'h012;
    send_data(8'($urandom), 9'd300, c);
    send_data(8'($urandom), 9'd300, c);
    check("abort_no_busy", n_fall - fall0, 0);
    check("abort_no_re", n_re - re0, 0);
    cmd(CMD_CONFIRM);
    wait_ready("abort_prog");
    check_writes("abort_prog");

    // Randomized programs with readback, and random reads
    for (int k = 0; k < 8; k++) begin
      row    = 9'($urandom_range(0, PAGES - 1));
      col_lo = 8'($urandom);
      nb     = $urandom_range(1, 6);
      do_prog("rnd_prog", col_lo, row, nb);
      do_read("rnd_back", CMD_READ0, col_lo, row, nb);
      do_read("rnd_rd", ($urandom_range(0, 1) != 0) ? CMD_READ1 : CMD_READ0,
              8'($urandom), 9'($urandom_range(0, PAGES - 1)), $urandom_range(1, 4));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
